// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment driver: one-hot select in, active-low anodes/cathodes out,
// with anode dead-time and frame-synchronous display updates. Option: LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  sel_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        err_o
);

    localparam int NUM_DIG = 4;
    localparam int CW      = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [3:0]          sel_q;
    logic [3:0]          an_q;
    logic [6:0]          seg_q;
    logic                err_q;
    logic [15:0]         shadow_q;
    logic [15:0]         disp_q;

    logic [NUM_DIG-1:0][3:0] nib;
    logic [NUM_DIG-1:0]      blank;
    logic [NUM_DIG-1:0][6:0] dig_seg;
    logic [6:0]              seg_d;
    logic [3:0]              an_d;
    logic                    sel_i_ok;
    logic                    sel_q_ok;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign nib = disp_q;

`ifdef LEADING_ZERO_BLANK_EN
    // lz[k]: nibbles k..3 all zero; digit 0 is never blanked so it has no lz bit
    logic [NUM_DIG-1:1] lz;
    assign lz[NUM_DIG-1] = (nib[NUM_DIG-1] == 4'h0);
    for (genvar k = 1; k < NUM_DIG - 1; k++) begin : g_lz
        assign lz[k] = lz[k+1] & (nib[k] == 4'h0);
    end
    assign blank = {lz, 1'b0};
`else
    assign blank = '0;
`endif

    for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
        assign dig_seg[k] = blank[k] ? 7'b1111111 : hex7(nib[k]);
    end

    // Active-low patterns: AND-ing the selected digits picks the one lit digit
    always_comb begin
        seg_d = 7'b1111111;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (sel_q[k]) seg_d = seg_d & dig_seg[k];
        end
    end

    assign an_d     = ~sel_q;
    assign sel_i_ok = (sel_i != 4'b0000) && ((sel_i & (sel_i - 4'd1)) == 4'b0000);
    assign sel_q_ok = (sel_q != 4'b0000) && ((sel_q & (sel_q - 4'd1)) == 4'b0000);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_BLANK;
            cnt_q    <= CNT_INIT;
            sel_q    <= 4'b0000;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
            err_q    <= 1'b0;
            shadow_q <= 16'h0000;
            disp_q   <= 16'h0000;
        end else begin
            if (load_i) shadow_q <= value_i;

            if (sel_i != sel_q) begin
                sel_q   <= sel_i;
                state_q <= ST_BLANK;
                cnt_q   <= CNT_INIT;
                an_q    <= 4'b1111;
                seg_q   <= 7'b1111111;
                if (!sel_i_ok) err_q <= 1'b1;
                // Frame boundary: a same-cycle load takes effect without waiting a frame
                if (sel_i == 4'b1000) disp_q <= load_i ? value_i : shadow_q;
            end else begin
                case (state_q)
                    ST_BLANK: begin
                        an_q  <= 4'b1111;
                        seg_q <= 7'b1111111;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else if (sel_q_ok) begin
                            state_q <= ST_DRIVE;
                            an_q    <= an_d;
                            seg_q   <= seg_d;
                        end
                    end
                    default: begin
                        an_q  <= an_d;
                        seg_q <= seg_d;
                    end
                endcase
            end
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign err_o = err_q;

endmodule
